encode_time_tx: RTL

- Transmit-side companion to the key decoder. It turns a captured BCD time value into an ASCII byte stream of the form "HH:MM:SS" followed by an optional alarm marker, CR and optional LF.
- It drives the UART transmit path one character at a time using a valid/ready handshake.
- It sits between the clock/alarm datapath and the UART TX serializer.

---
 rtl/encode_time_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/encode_time_tx.sv
// Serialises a captured BCD time as ASCII "HH:MM:SS[@]\r[\n]" over a valid/ready byte stream.
// Each new message captures its time fields once, at start, and holds them until the message ends.
module encode_time_tx #(
  parameter bit         WITH_LF    = 1'b1,
  parameter logic [7:0] ALARM_CHAR = 8'h40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] di_hrs,
  input  logic [7:0] di_min,
  input  logic [7:0] di_sec,
  input  logic       alarm_flag,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CHR_COLON = 8'h3A;
  localparam logic [BYTE_W-1:0] CHR_CR    = 8'h0D;
  localparam logic [BYTE_W-1:0] CHR_LF    = 8'h0A;
  localparam logic [BYTE_W-1:0] CHR_BAD   = 8'h3F;
  localparam logic [BYTE_W-1:0] CHR_ZERO  = 8'h30;

  typedef enum logic {IDLE, SEND} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] hrs_q, hrs_d;
  logic [BYTE_W-1:0] min_q, min_d;
  logic [BYTE_W-1:0] sec_q, sec_d;
  logic              alarm_q, alarm_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  last_idx;

  function automatic logic [BYTE_W-1:0] digit(input logic [3:0] n);
    return (n <= 4'd9) ? (CHR_ZERO + BYTE_W'(n)) : CHR_BAD;
  endfunction

  // Byte at position idx of the message built from the given capture.
  function automatic logic [BYTE_W-1:0] char_at(input logic [IDX_W-1:0]  idx,
                                                input logic [BYTE_W-1:0] h,
                                                input logic [BYTE_W-1:0] m,
                                                input logic [BYTE_W-1:0] s,
                                                input logic              a);
    logic [BYTE_W-1:0] c;
    c = CHR_LF;
    case (idx)
      4'd0:    c = digit(h[7:4]);
      4'd1:    c = digit(h[3:0]);
      4'd2:    c = CHR_COLON;
      4'd3:    c = digit(m[7:4]);
      4'd4:    c = digit(m[3:0]);
      4'd5:    c = CHR_COLON;
      4'd6:    c = digit(s[7:4]);
      4'd7:    c = digit(s[3:0]);
      4'd8:    c = a ? ALARM_CHAR : CHR_CR;
      4'd9:    c = a ? CHR_CR : CHR_LF;
      default: c = CHR_LF;
    endcase
    return c;
  endfunction

  assign last_idx = 4'd8 + IDX_W'(alarm_q) + IDX_W'(WITH_LF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hrs_q   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      alarm_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hrs_q   <= hrs_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      alarm_q <= alarm_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Next-state: capture on start in IDLE, advance one byte per accepted transfer in SEND.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hrs_d   = hrs_q;
    min_d   = min_q;
    sec_d   = sec_q;
    alarm_d = alarm_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          hrs_d   = di_hrs;
          min_d   = di_min;
          sec_d   = di_sec;
          alarm_d = alarm_flag;
          idx_d   = '0;
          data_d  = char_at('0, di_hrs, di_min, di_sec, alarm_flag);
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q == last_idx) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + 4'd1;
            data_d = char_at(idx_q + 4'd1, hrs_q, min_q, sec_q, alarm_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_valid = (state_q == SEND);
  assign busy     = (state_q == SEND);
  assign tx_data  = data_q;
  assign done     = done_q;

endmodule
